// File: rtl/mul_trunc_pkg.sv
// mul_trunc_pkg: shared types and helpers
// for the pipelined truncated multiplier.
package mul_trunc_pkg;

  typedef enum logic {
    MODE_EXACT  = 1'b0,
    MODE_APPROX = 1'b1
  } mode_e;

  function automatic bit keep_pp(
    input int i,
    input int j,
    input int trunc
  );
    return (i + j) >= trunc;
  endfunction

  function automatic logic [63:0] sat_add(
    input logic [63:0] x,
    input logic [63:0] y,
    input int          width
  );
    logic [64:0] s;
    logic [64:0] lim;
    s   = {1'b0, x} + {1'b0, y};
    lim = (65'd1 << width) - 65'd1;
    return (s > lim) ? lim[63:0] : s[63:0];
  endfunction

  function automatic bit cfg_ok(
    input int          w,
    input int          trunc,
    input logic [63:0] comp,
    input int          ps
  );
    logic [63:0] m;
    m = (64'd1 << trunc) - 64'd1;
    return (w >= 4) && (w <= 32)
        && (trunc >= 0) && (trunc < 2 * w)
        && ((comp & m) == 64'd0)
        && (ps >= 1) && (ps <= 4);
  endfunction

endpackage

// File: rtl/mul_trunc_pipe_if.sv
// mul_trunc_pipe_if: operand and result
// streams of the truncated multiplier.
interface mul_trunc_pipe_if
  import mul_trunc_pkg::*;
#(
  parameter int W = 12
) ();

  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  mode_e          approx;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] o;

  modport master (
    output in_valid, a, b, approx, out_ready,
    input  in_ready, out_valid, o
  );

  modport slave (
    input  in_valid, a, b, approx, out_ready,
    output in_ready, out_valid, o
  );

endinterface

// File: rtl/mul_trunc_ppred.sv
// mul_trunc_ppred: masked partial products
// reduced to a sum/carry pair.
module mul_trunc_ppred
  import mul_trunc_pkg::*;
#(
  parameter int W     = 12,
  parameter int TRUNC = 12
) (
  input  logic [W-1:0]   i_a,
  input  logic [W-1:0]   i_b,
  input  mode_e          i_approx,
  output logic [2*W-1:0] o_sum,
  output logic [2*W-1:0] o_carry
);

  logic [2*W-1:0] w_row;
  logic [2*W-1:0] w_s;
  logic [2*W-1:0] w_c;
  logic [2*W-1:0] w_t;

  // one row per multiplier bit, folded into s/c by 3:2 compressors
  always_comb begin
    w_row = '0;
    w_s   = '0;
    w_c   = '0;
    w_t   = '0;
    for (int j = 0; j < W; j++) begin
      w_row = '0;
      for (int i = 0; i < W; i++) begin
        if (i_approx == MODE_EXACT || keep_pp(i, j, TRUNC)) begin
          w_row[i+j] = i_a[i] & i_b[j];
        end
      end
      w_t = w_s ^ w_c ^ w_row;
      w_c = ((w_s & w_c) | (w_s & w_row) | (w_c & w_row)) << 1;
      w_s = w_t;
    end
    o_sum   = w_s;
    o_carry = w_c;
  end

endmodule

// File: rtl/mul_trunc_pipe.sv
// mul_trunc_pipe: valid/ready pipelined multiplier,
// exact or column-truncated with compensation.
module mul_trunc_pipe
  import mul_trunc_pkg::*;
#(
  parameter int          W           = 12,
  parameter int          TRUNC       = 12,
  parameter logic [63:0] COMP        = 64'd0,
  parameter int          PIPE_STAGES = 2
) (
  input logic             clk,
  input logic             rst,
  mul_trunc_pipe_if.slave bus
);

  localparam int W2 = 2 * W;

  if (!cfg_ok(W, TRUNC, COMP, PIPE_STAGES)) begin : g_bad_cfg
    $error("mul_trunc_pipe: illegal parameter set");
  end

  logic                   w_adv;
  logic [PIPE_STAGES-1:0] r_v;
  logic [W-1:0]           w_pa;
  logic [W-1:0]           w_pb;
  mode_e                  w_papx;
  logic [W2-1:0]          w_ps;
  logic [W2-1:0]          w_pc;
  logic [W2-1:0]          w_fs;
  logic [W2-1:0]          w_fc;
  mode_e                  w_fapx;
  logic                   w_fv;
  logic [W2-1:0]          w_sum;
  logic [63:0]            w_sat;
  logic [W2-1:0]          w_res;
  logic [W2-1:0]          r_o;

  assign w_adv         = ~r_v[PIPE_STAGES-1] | bus.out_ready;
  assign bus.in_ready  = w_adv;
  assign bus.out_valid = r_v[PIPE_STAGES-1];
  assign bus.o         = r_o;

  // stage valids shift together; bubbles are kept
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v <= '0;
    end else if (w_adv) begin
      r_v <= (r_v << 1) | PIPE_STAGES'(bus.in_valid);
    end
  end

  if (PIPE_STAGES >= 2) begin : g_in_reg
    logic [W-1:0] r_a;
    logic [W-1:0] r_b;
    mode_e        r_apx;

    // stage 0 captures the accepted operands
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_a   <= '0;
        r_b   <= '0;
        r_apx <= MODE_EXACT;
      end else if (w_adv && bus.in_valid) begin
        r_a   <= bus.a;
        r_b   <= bus.b;
        r_apx <= bus.approx;
      end
    end

    assign w_pa   = r_a;
    assign w_pb   = r_b;
    assign w_papx = r_apx;
    assign w_fv   = r_v[PIPE_STAGES-2];
  end else begin : g_in_comb
    assign w_pa   = bus.a;
    assign w_pb   = bus.b;
    assign w_papx = bus.approx;
    assign w_fv   = bus.in_valid;
  end

  mul_trunc_ppred #(
    .W     (W),
    .TRUNC (TRUNC)
  ) u_ppred (
    .i_a      (w_pa),
    .i_b      (w_pb),
    .i_approx (w_papx),
    .o_sum    (w_ps),
    .o_carry  (w_pc)
  );

  if (PIPE_STAGES > 2) begin : g_mid
    localparam int NM = PIPE_STAGES - 2;
    logic [NM-1:0][W2-1:0] r_s;
    logic [NM-1:0][W2-1:0] r_c;
    logic [NM-1:0]         r_apx;

    // sum/carry pair travels through the middle stages
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_s   <= '0;
        r_c   <= '0;
        r_apx <= '0;
      end else if (w_adv) begin
        if (r_v[0]) begin
          r_s[0]   <= w_ps;
          r_c[0]   <= w_pc;
          r_apx[0] <= w_papx;
        end
        for (int m = 1; m < NM; m++) begin
          if (r_v[m]) begin
            r_s[m]   <= r_s[m-1];
            r_c[m]   <= r_c[m-1];
            r_apx[m] <= r_apx[m-1];
          end
        end
      end
    end

    assign w_fs   = r_s[NM-1];
    assign w_fc   = r_c[NM-1];
    assign w_fapx = mode_e'(r_apx[NM-1]);
  end else begin : g_nomid
    assign w_fs   = w_ps;
    assign w_fc   = w_pc;
    assign w_fapx = w_papx;
  end

  assign w_sum = w_fs + w_fc;
  assign w_sat = sat_add(64'(w_sum), COMP, W2);
  assign w_res = (w_fapx == MODE_APPROX) ? w_sat[W2-1:0] : w_sum;

  if (W2 < 64) begin : g_sat_hi
    logic w_unused_sat;
    assign w_unused_sat = ^w_sat[63:W2];
  end

  // result register; holds through bubbles and stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_o <= '0;
    end else if (w_adv && w_fv) begin
      r_o <= w_res;
    end
  end

endmodule

// File: tb/tb_mul_trunc_pipe.sv
// tb_mul_trunc_pipe: scoreboard bench with a
// bit-level reference model and config sweep.
module tb_mul_trunc_pipe;
  import mul_trunc_pkg::*;

  localparam int          W  = 12;
  localparam logic [63:0] C3 = 64'hFFF000;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   stall_en = 1'b0;
  int   pops = 0;
  int   first_pop = 0;
  int   last_pop = 0;

  logic [23:0] exp_q[$];

  logic        sw_v;
  logic [11:0] sw_a;
  logic [11:0] sw_b;
  mode_e       sw_apx;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mul_trunc_pipe_if #(.W(W)) bus ();
  mul_trunc_pipe_if #(.W(W)) sif1 ();
  mul_trunc_pipe_if #(.W(W)) sif2 ();
  mul_trunc_pipe_if #(.W(W)) sif3 ();

  assign sif1.in_valid = sw_v;
  assign sif1.a = sw_a;
  assign sif1.b = sw_b;
  assign sif1.approx = sw_apx;
  assign sif1.out_ready = 1'b1;
  assign sif2.in_valid = sw_v;
  assign sif2.a = sw_a;
  assign sif2.b = sw_b;
  assign sif2.approx = sw_apx;
  assign sif2.out_ready = 1'b1;
  assign sif3.in_valid = sw_v;
  assign sif3.a = sw_a;
  assign sif3.b = sw_b;
  assign sif3.approx = sw_apx;
  assign sif3.out_ready = 1'b1;

  mul_trunc_pipe #(.W(W), .TRUNC(12), .COMP(64'd0), .PIPE_STAGES(2))
    dut (.clk(clk), .rst(rst), .bus(bus));
  mul_trunc_pipe #(.W(W), .TRUNC(0), .COMP(64'd0), .PIPE_STAGES(1))
    dut1 (.clk(clk), .rst(rst), .bus(sif1));
  mul_trunc_pipe #(.W(W), .TRUNC(20), .COMP(64'd0), .PIPE_STAGES(4))
    dut2 (.clk(clk), .rst(rst), .bus(sif2));
  mul_trunc_pipe #(.W(W), .TRUNC(12), .COMP(C3), .PIPE_STAGES(2))
    dut3 (.clk(clk), .rst(rst), .bus(sif3));

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [23:0] model(
    input int unsigned a, input int unsigned b, input bit apx,
    input int tr, input longint unsigned comp);
    longint unsigned p;
    if (!apx) return 24'(a * b);
    p = 0;
    for (int i = 0; i < W; i++)
      for (int j = 0; j < W; j++)
        if (i + j >= tr && a[i] && b[j]) p += 64'd1 << (i + j);
    p += comp;
    if (p > 64'hFFFFFF) p = 64'hFFFFFF;
    return p[23:0];
  endfunction

  task automatic send(input int unsigned a, input int unsigned b,
                      input bit apx, input logic [23:0] e,
                      output int acc);
    int n = 0;
    bus.in_valid = 1'b1;
    bus.a = 12'(a);
    bus.b = 12'(b);
    bus.approx = apx ? MODE_APPROX : MODE_EXACT;
    @(negedge clk);
    while (!bus.in_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    acc = cyc;
    if (bus.in_ready) exp_q.push_back(e);
    else chk("accept_timeout", 64'(n), 64'(0));
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic lat_chk(input int acc, input int lat, input string nm);
    int n = 0;
    @(negedge clk);
    while (!bus.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 64'(cyc - acc), 64'(lat));
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string nm);
    int n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 64'(exp_q.size()), 64'(0));
    @(posedge clk);
    #1;
  endtask

  task automatic sweep_beat(input int unsigned a, input int unsigned b,
                            input bit apx, input logic [23:0] e1,
                            input logic [23:0] e2, input logic [23:0] e3);
    int acc;
    int l1 = -1;
    int l2 = -1;
    int l3 = -1;
    logic [23:0] o1 = '0;
    logic [23:0] o2 = '0;
    logic [23:0] o3 = '0;
    sw_v = 1'b1;
    sw_a = 12'(a);
    sw_b = 12'(b);
    sw_apx = apx ? MODE_APPROX : MODE_EXACT;
    @(negedge clk);
    acc = cyc;
    chk("sw_ready", 64'(sif1.in_ready & sif2.in_ready & sif3.in_ready), 64'(1));
    @(posedge clk);
    #1;
    sw_v = 1'b0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (sif1.out_valid && l1 < 0) begin l1 = cyc - acc; o1 = sif1.o; end
      if (sif2.out_valid && l2 < 0) begin l2 = cyc - acc; o2 = sif2.o; end
      if (sif3.out_valid && l3 < 0) begin l3 = cyc - acc; o3 = sif3.o; end
    end
    chk("sw_p1_lat", 64'(l1), 64'(1));
    chk("sw_p1_t0_val", 64'(o1), 64'(e1));
    chk("sw_p4_lat", 64'(l2), 64'(4));
    chk("sw_p4_t20_val", 64'(o2), 64'(e2));
    chk("sw_comp_lat", 64'(l3), 64'(2));
    chk("sw_comp_val", 64'(o3), 64'(e3));
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = stall_en ? ($urandom_range(0, 1) == 1) : 1'b1;
    end
  end

  initial begin
    bit          prev_stall = 1'b0;
    logic [23:0] prev_o = '0;
    logic [23:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        chk("in_ready", 64'(bus.in_ready), 64'(!(bus.out_valid && !bus.out_ready)));
        if (prev_stall) begin
          chk("hold_valid", 64'(bus.out_valid), 64'(1));
          chk("hold_o", 64'(bus.o), 64'(prev_o));
        end
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL extra_out: got %0h expected no beat", bus.o);
          end else begin
            e = exp_q.pop_front();
            chk("result", 64'(bus.o), 64'(e));
            if (pops == 0) first_pop = cyc;
            last_pop = cyc;
            pops++;
          end
        end
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_o = bus.o;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc;
    int unsigned ra;
    int unsigned rb;
    bit rp;
    int stale;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.approx = MODE_EXACT;
    sw_v = 1'b0;
    sw_a = '0;
    sw_b = '0;
    sw_apx = MODE_EXACT;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_o", 64'(bus.o), 64'(0));
    chk("rst_in_ready", 64'(bus.in_ready), 64'(1));
    rst = 1'b0;
    @(posedge clk);
    #1;

    sweep_beat(4095, 4095, 1'b1, 24'hFFE001,
               model(4095, 4095, 1'b1, 20, 0), 24'hFFFFFF);
    sweep_beat(4095, 4095, 1'b0, 24'hFFE001, 24'hFFE001, 24'hFFE001);
    repeat (4) begin
      ra = $urandom_range(0, 4095);
      rb = $urandom_range(0, 4095);
      sweep_beat(ra, rb, 1'b1, 24'(ra * rb),
                 model(ra, rb, 1'b1, 20, 0), model(ra, rb, 1'b1, 12, C3));
    end

    send(4095, 4095, 1'b0, 24'hFFE001, acc);
    lat_chk(acc, 2, "lat_exact");
    send(4095, 4095, 1'b1, 24'hFF3000, acc);
    lat_chk(acc, 2, "lat_approx");
    send(1, 1, 1'b1, 24'h0, acc);
    send(1, 1, 1'b0, 24'h1, acc);
    send(4095, 1, 1'b1, 24'h0, acc);
    send(2048, 2048, 1'b1, 24'h400000, acc);
    send(2048, 2048, 1'b0, 24'h400000, acc);
    drain("drain_directed");

    pops = 0;
    for (int k = 0; k < 64; k++) begin
      ra = $urandom_range(0, 4095);
      rb = $urandom_range(0, 4095);
      rp = 1'($urandom_range(0, 1));
      send(ra, rb, rp, model(ra, rb, rp, 12, 0), acc);
    end
    drain("drain_stream");
    chk("stream_count", 64'(pops), 64'(64));
    chk("stream_rate", 64'(last_pop - first_pop), 64'(63));

    pops = 0;
    stall_en = 1'b1;
    for (int k = 0; k < 150; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      ra = ($urandom_range(0, 7) == 0) ? 4095 : $urandom_range(0, 4095);
      rb = $urandom_range(0, 4095);
      rp = 1'($urandom_range(0, 1));
      send(ra, rb, rp, model(ra, rb, rp, 12, 0), acc);
    end
    stall_en = 1'b0;
    drain("drain_stall");
    chk("stall_count", 64'(pops), 64'(150));

    send(3000, 3000, 1'b0, model(3000, 3000, 1'b0, 12, 0), acc);
    send(1234, 4000, 1'b1, model(1234, 4000, 1'b1, 12, 0), acc);
    rst = 1'b1;
    #1;
    chk("rst_mid_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_mid_o", 64'(bus.o), 64'(0));
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    stale = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.out_valid) stale++;
    end
    chk("rst_stale", 64'(stale), 64'(0));
    @(posedge clk);
    #1;
    send(77, 99, 1'b0, 24'(77 * 99), acc);
    lat_chk(acc, 2, "lat_after_rst");
    drain("drain_final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
